// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared constants and types for the RTC time-set input block
package rtc_pkg;

    localparam int BTN_SEC = 0;
    localparam int BTN_MIN = 1;
    localparam int BTN_HR  = 2;
    localparam int NUM_BTN = 3;

    localparam int CLK_HZ = 50_000_000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

endpackage

// File: rtl/rtc_set_input_debounce_cell.sv
// rtl/rtc_set_input_debounce_cell.sv - 2-flop synchronizer plus tick-sampled shift-register debouncer
module debounce_cell #(
    parameter int DB_DEPTH = 8,
    parameter bit INVERT   = 1'b0
) (
    input  logic clk50M,
    input  logic resetn,
    input  logic tick,
    input  logic raw,
    output logic level
);

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic [DB_DEPTH-1:0] shift_q, shift_d;
    logic                level_q, level_d;

    // Level is judged on the freshly shifted value so it moves on the same tick
    always_comb begin
        sync1_d = raw ^ INVERT;
        sync2_d = sync1_q;
        shift_d = shift_q;
        level_d = level_q;
        if (tick) begin
            shift_d = (shift_q << 1) | DB_DEPTH'(sync2_q);
            if (&shift_d) begin
                level_d = 1'b1;
            end else if (~|shift_d) begin
                level_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk50M or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            shift_q <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            shift_q <= shift_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/rtc_set_input.sv
// rtl/rtc_set_input.sv - debounced set-mode switch and auto-repeating column increment buttons
module rtc_set_input
    import rtc_pkg::*;
#(
    parameter int TICK_DIV     = CLK_HZ / 1000,
    parameter int DB_DEPTH     = 8,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 125
) (
    input  logic                clk50M,
    input  logic                resetn,
    input  logic [NUM_BTN-1:0]  push_button,
    input  logic                man_switch,
    output logic [NUM_BTN-1:0]  inc_pulse,
    output logic                man_mode,
    output logic [NUM_BTN-1:0]  btn_level
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(REPEAT_DELAY + 1);

    logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
    logic               tick;
    logic [NUM_BTN-1:0] btn_lvl;
    logic               man_lvl;

    always_comb begin
        tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debounce_cell #(.DB_DEPTH(DB_DEPTH), .INVERT(1'b1)) u_btn (
            .clk50M (clk50M),
            .resetn (resetn),
            .tick   (tick),
            .raw    (push_button[i]),
            .level  (btn_lvl[i])
        );
    end

    debounce_cell #(.DB_DEPTH(DB_DEPTH), .INVERT(1'b0)) u_man (
        .clk50M (clk50M),
        .resetn (resetn),
        .tick   (tick),
        .raw    (man_switch),
        .level  (man_lvl)
    );

    rpt_state_t         state_q   [NUM_BTN];
    rpt_state_t         state_d   [NUM_BTN];
    logic [CW-1:0]      rpt_cnt_q [NUM_BTN];
    logic [CW-1:0]      rpt_cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] level_prev_q, level_prev_d;
    logic [NUM_BTN-1:0] pulse_q, pulse_d;
    logic [NUM_BTN-1:0] rise;

    // Leaving DELAY/REPEAT on release or mode drop wins over a coinciding tick
    always_comb begin
        level_prev_d = btn_lvl;
        rise         = btn_lvl & ~level_prev_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            state_d[i]   = state_q[i];
            rpt_cnt_d[i] = rpt_cnt_q[i];
            pulse_d[i]   = 1'b0;
            case (state_q[i])
                IDLE: begin
                    if (rise[i] && man_lvl) begin
                        pulse_d[i]   = 1'b1;
                        rpt_cnt_d[i] = CW'(REPEAT_DELAY);
                        state_d[i]   = DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    if (!btn_lvl[i] || !man_lvl) begin
                        state_d[i]   = IDLE;
                        rpt_cnt_d[i] = '0;
                    end else if (tick) begin
                        if (rpt_cnt_q[i] == CW'(1)) begin
                            pulse_d[i]   = 1'b1;
                            rpt_cnt_d[i] = CW'(REPEAT_RATE);
                            state_d[i]   = REPEAT;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] - 1'b1;
                        end
                    end
                end
                default: begin
                    state_d[i]   = IDLE;
                    rpt_cnt_d[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk50M or negedge resetn) begin
        if (!resetn) begin
            tick_cnt_q   <= '0;
            level_prev_q <= '0;
            pulse_q      <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i]   <= IDLE;
                rpt_cnt_q[i] <= '0;
            end
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            level_prev_q <= level_prev_d;
            pulse_q      <= pulse_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i]   <= state_d[i];
                rpt_cnt_q[i] <= rpt_cnt_d[i];
            end
        end
    end

    // A pulse registered on the same tick that drops the level or the mode is suppressed
    assign inc_pulse = pulse_q & btn_lvl & {NUM_BTN{man_lvl}};
    assign man_mode  = man_lvl;
    assign btn_level = btn_lvl;

endmodule

// File: tb/tb_rtc_set_input.sv
// tb/tb_rtc_set_input.sv - self-checking bench for rtc_set_input against a tick-counting reference model
module tb_rtc_set_input;

    localparam int TD = 4;
    localparam int DB = 3;
    localparam int RD = 5;
    localparam int RR = 2;

    logic       clk50M = 1'b0;
    logic       resetn = 1'b1;
    logic [2:0] push_button = 3'b111;
    logic       man_switch = 1'b0;
    logic [2:0] inc_pulse;
    logic       man_mode;
    logic [2:0] btn_level;

    always #10 clk50M = ~clk50M;

    rtc_set_input #(
        .TICK_DIV     (TD),
        .DB_DEPTH     (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .clk50M      (clk50M),
        .resetn      (resetn),
        .push_button (push_button),
        .man_switch  (man_switch),
        .inc_pulse   (inc_pulse),
        .man_mode    (man_mode),
        .btn_level   (btn_level)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: edge count, raw delay line, run-length debounce, ticks since press
    int         edge_n;
    bit         d1 [4];
    bit         d2 [4];
    bit         lvl [4];
    bit         lvl_prev [4];
    bit         run_val [4];
    int         run_len [4];
    bit         active [3];
    int         ticks_since [3];
    logic [2:0] exp_pulse;

    int pulse_cnt [3];
    int all_cnt;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        edge_n = 0;
        for (int i = 0; i < 4; i++) begin
            d1[i] = 0; d2[i] = 0; lvl[i] = 0; lvl_prev[i] = 0;
            run_val[i] = 0; run_len[i] = DB;
        end
        for (int b = 0; b < 3; b++) begin
            active[b] = 0; ticks_since[b] = 0;
        end
        exp_pulse = 3'b000;
    endtask

    task automatic model_edge();
        bit raw [4];
        bit nl [4];
        bit is_tick;
        bit p;
        for (int i = 0; i < 3; i++) raw[i] = ~push_button[i];
        raw[3] = man_switch;
        edge_n++;
        is_tick = (edge_n % TD) == 0;
        for (int i = 0; i < 4; i++) begin
            nl[i] = lvl[i];
            if (is_tick) begin
                if (d2[i] == run_val[i]) run_len[i]++;
                else begin run_val[i] = d2[i]; run_len[i] = 1; end
                if (run_len[i] >= DB) nl[i] = run_val[i];
            end
        end
        for (int b = 0; b < 3; b++) begin
            p = 0;
            if (active[b]) begin
                if (!lvl[b] || !lvl[3]) active[b] = 0;
                else if (is_tick) begin
                    ticks_since[b]++;
                    if (ticks_since[b] == RD || (ticks_since[b] > RD && (ticks_since[b] - RD) % RR == 0))
                        p = 1;
                end
            end else if (lvl[b] && !lvl_prev[b] && lvl[3]) begin
                p = 1; active[b] = 1; ticks_since[b] = 0;
            end
            exp_pulse[b] = p & nl[b] & nl[3];
        end
        for (int i = 0; i < 4; i++) begin
            d2[i] = d1[i]; d1[i] = raw[i];
            lvl_prev[i] = lvl[i]; lvl[i] = nl[i];
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk50M);
            model_edge();
            @(negedge clk50M);
            chk("inc_pulse", inc_pulse, exp_pulse);
            chk("btn_level", btn_level, {lvl[2], lvl[1], lvl[0]});
            chk("man_mode", {2'b00, man_mode}, {2'b00, lvl[3]});
            for (int b = 0; b < 3; b++) pulse_cnt[b] += int'(inc_pulse[b]);
            if (inc_pulse == 3'b111) all_cnt++;
        end
    endtask

    task automatic clear_counts();
        for (int b = 0; b < 3; b++) pulse_cnt[b] = 0;
        all_cnt = 0;
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk50M);
        resetn = 1'b0;
        model_reset();
        #1;
        chk("rst_inc_pulse", inc_pulse, 3'b000);
        chk("rst_btn_level", btn_level, 3'b000);
        chk("rst_man_mode", {2'b00, man_mode}, 3'b000);
        repeat (n) @(negedge clk50M);
        chk("rst_hold_inc_pulse", inc_pulse, 3'b000);
        chk("rst_hold_btn_level", btn_level, 3'b000);
        resetn = 1'b1;
    endtask

    initial begin
        clear_counts();
        model_reset();

        // Buttons held through reset debounce to pressed; mode is off so no pulses
        push_button = 3'b000;
        man_switch  = 1'b0;
        apply_reset(3);
        cyc(3 * TD - 1);
        chk("btn_level_before_3_ticks", btn_level, 3'b000);
        cyc(1);
        chk("btn_level_after_3_ticks", btn_level, 3'b111);
        cyc(10);
        chk_int("no_pulse_mode_off", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2], 0);

        // Mode rising while already pressed must not pulse
        man_switch = 1'b1;
        clear_counts();
        cyc(30);
        chk_int("no_pulse_held_at_mode_rise", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2], 0);
        push_button = 3'b111;
        cyc(30);

        // Bounce on the seconds button
        clear_counts();
        for (int t = 0; t < 8; t++) begin
            push_button[0] = ~push_button[0];
            cyc(5);
        end
        chk_int("bounce_no_early_pulse", pulse_cnt[0], 0);
        push_button[0] = 1'b0;
        cyc(2 + DB * TD + 4);
        chk_int("bounce_single_pulse", pulse_cnt[0], 1);
        push_button[0] = 1'b1;
        cyc(30);

        // Auto-repeat on the minutes button
        clear_counts();
        push_button[1] = 1'b0;
        cyc(20 * TD);
        chk_int("repeat_count_in_range", int'(pulse_cnt[1] >= 7 && pulse_cnt[1] <= 9), 1);
        push_button[1] = 1'b1;
        cyc(30);

        // Mode drop while hours button is repeating
        push_button[2] = 1'b0;
        cyc(80);
        man_switch = 1'b0;
        cyc(2 + DB * TD + 4);
        chk("mode_dropped", {2'b00, man_mode}, 3'b000);
        clear_counts();
        cyc(40);
        chk_int("no_pulse_after_mode_drop", pulse_cnt[2], 0);
        man_switch = 1'b1;
        cyc(40);
        chk_int("no_pulse_mode_back_still_held", pulse_cnt[2], 0);
        push_button[2] = 1'b1;
        cyc(30);

        // Simultaneous press of all three
        clear_counts();
        push_button = 3'b000;
        cyc(30);
        chk_int("simultaneous_111_cycles", all_cnt, 1);
        push_button = 3'b111;
        cyc(30);

        // Reset during DELAY, button held through it
        push_button[0] = 1'b0;
        cyc(24);
        apply_reset(2);
        clear_counts();
        cyc(10);
        chk_int("no_pulse_on_reset_release", pulse_cnt[0], 0);
        cyc(30);
        chk_int("fresh_press_after_reset", int'(pulse_cnt[0] >= 1), 1);
        push_button = 3'b111;
        cyc(30);

        // Randomized activity against the model
        for (int r = 0; r < 40; r++) begin
            push_button = 3'($urandom);
            man_switch  = ($urandom % 4) != 0;
            if ($urandom % 3 == 0) cyc($urandom_range(1, 3));
            else cyc($urandom_range(5, 60));
        end
        push_button = 3'b111;
        cyc(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtc_set_input.md
# rtc_set_input

Conditions the raw time-set inputs of the real-time clock: three active-low push buttons and the manual-set toggle switch. It synchronizes and debounces them, then produces one-cycle increment pulses for the seconds, minutes and hours columns, with auto-repeat while a button is held. It sits directly upstream of the HH:MM:SS counter/display block. That block consumes `man_mode` and `inc_pulse` to advance columns while in set mode.

## Interface
Parameters:
- `TICK_DIV`, default 50000: clk50M cycles per sample tick (1 kHz).
- `DB_DEPTH`, default 8: consecutive equal samples required to change a debounced level.
- `REPEAT_DELAY`, default 500: ticks from the initial press pulse to the first repeat pulse.
- `REPEAT_RATE`, default 125: ticks between subsequent repeat pulses.

Ports:
- `clk50M`  in  1  50 MHz clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `push_button`  in  3  raw buttons, active-low; bit0 = seconds, bit1 = minutes, bit2 = hours.
- `man_switch`  in  1  raw set-mode switch; 1 = manual.
- `inc_pulse`  out  3  one-cycle increment request per column, same bit mapping as `push_button`.
- `man_mode`  out  1  debounced `man_switch`.
- `btn_level`  out  3  debounced pressed state; 1 = pressed.

## Operation
- Synchronization: each raw input passes through a 2-flop synchronizer. Buttons are inverted so that 1 = pressed.
- Tick generator: free-running counter over 0..TICK_DIV-1. `tick` is high for the single cycle in which the count equals TICK_DIV-1.
- Debounce: on each `tick`, the synchronized value shifts into a DB_DEPTH-bit shift register.
  - The level goes to 1 when all bits are 1, and to 0 when all bits are 0.
  - Otherwise the level holds.
  - The level register updates on the same edge as the shift.
- Per-button FSM with states IDLE, DELAY and REPEAT, plus a down-counter `rpt_cnt` (width clog2(REPEAT_DELAY+1)).
  - IDLE: when `btn_level` rises and `man_mode`=1, pulse, load `rpt_cnt`=REPEAT_DELAY, and go to DELAY.
  - DELAY: on `tick`, decrement. On a tick with `rpt_cnt`==1, pulse, load REPEAT_RATE, and go to REPEAT.
  - REPEAT: on `tick`, decrement. On a tick with `rpt_cnt`==1, pulse and reload REPEAT_RATE.
  - From DELAY or REPEAT, `btn_level`=0 or `man_mode`=0 returns to IDLE with no pulse. This has priority over a coinciding decrement or pulse.
- Buttons are independent. Several `inc_pulse` bits may assert in the same cycle.
- `man_mode`=0 forces `inc_pulse`=0 in all cases.
- A button already pressed when `man_mode` rises generates nothing until it is released and pressed again, because a rising edge of `btn_level` is required.
- Reset values: `inc_pulse`=0, `man_mode`=0, `btn_level`=0, all FSMs in IDLE, all counters and shift registers at 0.
- Reset asserted mid-operation aborts immediately, with no pulse on deassertion.
- A button held through reset is seen as a fresh press once it has debounced.

## Timing
- Synchronizer: 2 cycles.
- Debounce: the level rises on the tick carrying the DB_DEPTH-th consecutive pressed sample. Worst-case latency from a stable raw edge to the level change is 2 + DB_DEPTH×TICK_DIV cycles.
- `inc_pulse` is registered. It is high for exactly one cycle: the cycle after the `btn_level` rise, or the cycle after the qualifying tick.
- First repeat pulse: exactly REPEAT_DELAY ticks after the initial pulse, ±1 tick depending on tick phase.
- Later repeat pulses: every REPEAT_RATE×TICK_DIV cycles.
- Release: `btn_level` falls DB_DEPTH ticks after a stable release. No pulse occurs after that cycle.

## Structure
- Package `rtc_pkg` holds:
  - button index constants `BTN_SEC`=0, `BTN_MIN`=1, `BTN_HR`=2;
  - the FSM state enum `rpt_state_t` {IDLE, DELAY, REPEAT};
  - the default clock constant `CLK_HZ`=50_000_000.
- Sub-module `debounce_cell` contains the synchronizer, shift register and level register. It takes `tick` and a raw bit and outputs the level. It is instantiated 4 times.
- The top level holds the tick generator, three repeat FSMs and the output registers.

## Test plan
Simulation parameters: TICK_DIV=4, DB_DEPTH=3, REPEAT_DELAY=5, REPEAT_RATE=2.
- Reset: hold `resetn`=0 while driving all buttons low. Required: all outputs 0. After release, `btn_level`=3'b111 after 3 ticks, and `inc_pulse`=0 because `man_mode`=0.
- Bounce: with `man_mode`=1, toggle `push_button[0]` every 5 cycles for 40 cycles, then hold it low. Required: exactly one `inc_pulse[0]`, 1 cycle wide, within 2+12 cycles of the stable low.
- Auto-repeat: hold `push_button[1]` low for 20 ticks. Required: `inc_pulse[1]` at the press, then at +5 ticks, then every 2 ticks, for a total of 8 pulses, ±1.
- Mode drop: drop `man_switch` while `push_button[2]` is held in REPEAT. Required: after `man_mode` falls, no further pulses, and the FSM is in IDLE.
- Simultaneous: press all three buttons on the same cycle. Required: `inc_pulse`=3'b111 in a single cycle.
- Mid-press reset: assert `resetn` during DELAY. Required: outputs go to 0 immediately.
